univ_shift_reg: RTL

Parametrised universal shift register. Generalises the fixed 4-bit parallel-in/parallel-out register to WIDTH bits with four per-cycle modes: hold, shift right, shift left and parallel load. Adds an automatic serialise/deserialise sequencer that performs exactly WIDTH shifts after a start pulse, with a busy/done handshake. Used as the common shift/serdes building block in the sequential-circuits library.

---
 rtl/univ_shift_pkg.sv | 28 ++
 rtl/shift_bit_counter.sv | 36 +++
 rtl/univ_shift_reg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
//------------------------------------------------------------------------------
// Module   : univ_shift_pkg
// Purpose  : Shared types and constants for the universal shift register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package univ_shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage : univ_shift_pkg

`default_nettype wire

// File: rtl/shift_bit_counter.sv
//------------------------------------------------------------------------------
// Module   : shift_bit_counter
// Purpose  : Shift-count tracker with clear, increment and terminal count
//            (tc high while the count equals WIDTH-1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign tc = (r_count == CW'(WIDTH - 1));

endmodule : shift_bit_counter

`default_nettype wire

// File: rtl/univ_shift_reg.sv
//------------------------------------------------------------------------------
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register (hold/shr/shl/load) with an
//            automatic WIDTH-shift serdes sequencer. Optional rotate input
//            enabled by macro UNIV_SHIFT_ROTATE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic             dir,
`ifdef UNIV_SHIFT_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] par_out,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic             r_dir;
   logic             r_busy;
   logic             r_done;

   logic             w_in_r;
   logic             w_in_l;
   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_shl;
   logic             w_tc;
   logic             w_clr;
   logic             w_inc;

   // Under rotation the outgoing end bit is fed back instead of the serial input.
`ifdef UNIV_SHIFT_ROTATE_EN
   assign w_in_r = rot ? r_data[0]       : ser_in_r;
   assign w_in_l = rot ? r_data[WIDTH-1] : ser_in_l;
`else
   assign w_in_r = ser_in_r;
   assign w_in_l = ser_in_l;
`endif

   assign w_shr = {w_in_r, r_data[WIDTH-1:1]};
   assign w_shl = {r_data[WIDTH-2:0], w_in_l};

   assign w_clr = (r_state == IDLE) && start;
   assign w_inc = (r_state == SHIFT);

   shift_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .inc (w_inc),
      .tc  (w_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_data  <= RST_VAL;
         r_dir   <= DIR_RIGHT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_dir   <= dir;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end else if (en) begin
                  case (mode_t'(mode))
                     MODE_SHR:  r_data <= w_shr;
                     MODE_SHL:  r_data <= w_shl;
                     MODE_LOAD: r_data <= par_in;
                     default:   r_data <= r_data;
                  endcase
               end
            end
            SHIFT: begin
               r_data <= (r_dir == DIR_LEFT) ? w_shl : w_shr;
               if (w_tc) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign par_out   = r_data;
   assign ser_out_r = r_data[0];
   assign ser_out_l = r_data[WIDTH-1];
   assign busy      = r_busy;
   assign done      = r_done;

endmodule : univ_shift_reg

`default_nettype wire
